// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life grid RAM.
//   clr_state_t : state encoding of the bulk-clear sequencer
//   GOL_CELL_W  : default cell word width
//   GOL_ADDR_W  : default grid address width
//   gol_parity  : even-parity bit of a zero-extended data word
package gol_pkg;

    localparam int unsigned GOL_CELL_W = 5;
    localparam int unsigned GOL_ADDR_W = 16;
    localparam int unsigned PAR_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Zero extension does not change parity, so one wide function serves any
    // cell width up to PAR_MAX_W.
    function automatic logic gol_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/gol_clr_seq.sv
// Bulk-clear sequencer for the grid RAM.
// Sweeps every address once, one word per cycle, then pulses clr_done.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_start   : single-cycle start pulse, ignored unless idle
//   sweep_addr  : address being cleared this cycle
//   sweep_we    : write strobe for sweep_addr
//   clr_busy    : high in CLEAR and DONE
//   clr_done    : one-cycle pulse in DONE
module gol_clr_seq
    import gol_pkg::*;
#(
    parameter int unsigned ADDR_W = GOL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we,
    output logic              clr_busy,
    output logic              clr_done
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                sweep_we = 1'b1;
                clr_busy = 1'b1;
                // Counter wraps to zero after the last word; no wider compare needed.
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                clr_busy = 1'b1;
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sweep_addr = cnt_q;

endmodule

// File: rtl/gol_ram_dp_clr.sv
// Dual-port grid RAM for the Game of Life engine with a bulk-clear sweep.
//   Port A : read-only display port, never stalled, latency 1 + A_OUT_REG.
//   Port B : engine read/write port, write-first, stalled while clearing.
//   Clear  : clr_start sweeps every word to CLR_VAL; clr_busy / clr_done report it.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   a_en, a_addr                  : port A read request
//   a_dout, a_valid, a_perr       : port A read data, valid flag, parity error
//   b_en, b_we, b_addr, b_din     : port B request
//   b_ready                       : port B accepts a request this cycle
//   b_dout, b_valid               : port B read data (write-first) and valid flag
//   clr_start, clr_busy, clr_done : clear sweep control and status
// Build option: define GOL_RAM_PARITY_EN to store an even-parity bit per word
// and check it on port A reads; otherwise a_perr is constant 0.
module gol_ram_dp_clr
    import gol_pkg::*;
#(
    parameter int unsigned       DATA_W    = GOL_CELL_W,
    parameter int unsigned       ADDR_W    = GOL_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL   = '0,
    parameter int unsigned       A_OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    output logic              a_perr,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_ready,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef GOL_RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] data);
`ifdef GOL_RAM_PARITY_EN
        return {gol_parity(PAR_MAX_W'(data)), data};
`else
        return data;
`endif
    endfunction

    logic [MEM_W-1:0] mem [DEPTH];

    // Clear sequencer
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_we;

    gol_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_start  (clr_start),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    // Port B is only accepted while the sequencer is idle.
    logic b_acc;
    assign b_ready = ~clr_busy;
    assign b_acc   = b_en & b_ready;

    // Shared write path: sweep and port B never write in the same cycle.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_word;

    always_comb begin
        wr_en   = b_acc & b_we;
        wr_addr = b_addr;
        wr_word = encode(b_din);
        if (sweep_we) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr;
            wr_word = encode(CLR_VAL);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // Port A first stage. Reads see the pre-edge contents, so a colliding
    // write on the same edge returns old data.
    logic [MEM_W-1:0]  a_word;
    logic              a_chk;
    logic [DATA_W-1:0] a1_data_q;
    logic              a1_valid_q;
    logic              a1_perr_q;

    assign a_word = mem[a_addr];
`ifdef GOL_RAM_PARITY_EN
    // Stored word carries even parity, so any odd XOR is a corruption.
    assign a_chk = ^a_word;
`else
    assign a_chk = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_data_q  <= '0;
            a1_valid_q <= 1'b0;
            a1_perr_q  <= 1'b0;
        end else begin
            a1_valid_q <= a_en;
            if (a_en) begin
                a1_data_q <= a_word[DATA_W-1:0];
                a1_perr_q <= a_chk;
            end
        end
    end

    // Optional second port A stage for timing closure.
    if (A_OUT_REG != 0) begin : g_a_out_reg
        logic [DATA_W-1:0] a2_data_q;
        logic              a2_valid_q;
        logic              a2_perr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a2_data_q  <= '0;
                a2_valid_q <= 1'b0;
                a2_perr_q  <= 1'b0;
            end else begin
                a2_valid_q <= a1_valid_q;
                if (a1_valid_q) begin
                    a2_data_q <= a1_data_q;
                    a2_perr_q <= a1_perr_q;
                end
            end
        end

        assign a_dout  = a2_data_q;
        assign a_valid = a2_valid_q;
        assign a_perr  = a2_perr_q;
    end else begin : g_a_direct
        assign a_dout  = a1_data_q;
        assign a_valid = a1_valid_q;
        assign a_perr  = a1_perr_q;
    end

    // Port B: write-first read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            b_valid <= b_acc;
            if (b_acc) begin
                if (b_we) begin
                    b_dout <= b_din;
                end else begin
                    b_dout <= mem[b_addr][DATA_W-1:0];
                end
            end
        end
    end

endmodule
